// File: rtl/logger_pkg.sv
// Shared definitions for the ADC serial reader: FSM encoding and default sizing.
package logger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } adc_state_e;

    localparam int ADC_DATA_W    = 16;
    localparam int ADC_SCLK_DIV  = 8;
    localparam int ADC_START_DLY = 4;

endpackage

// File: rtl/adc_serial_reader_if.sv
// ADC-side pins plus the parallel sample bus of the serial reader.
interface adc_serial_reader_if #(
    parameter int DATA_W = logger_pkg::ADC_DATA_W
);
    logic              en;
    logic              clr_ovr;
    logic              nDRDY;
    logic              SDIN1;
    logic              SCLK1;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              busy;
    logic              overrun;

    // The reader drives the serial clock and the sample bus.
    modport master (
        input  en, clr_ovr, nDRDY, SDIN1,
        output SCLK1, sample_data, sample_valid, busy, overrun
    );

    // The ADC / system side sees the mirror image.
    modport slave (
        output en, clr_ovr, nDRDY, SDIN1,
        input  SCLK1, sample_data, sample_valid, busy, overrun
    );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input, with an optional
// rising-edge pulse built from a third history flop.
module sync_edge_det #(
    parameter bit EDGE_OUT = 1'b1
) (
    input  logic clk,
    input  logic res,
    input  logic d,
    output logic q,
    output logic rise
);
    logic s1, s2;

    // Metastability chain; s2 is the first usable copy of d.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

    generate
        if (EDGE_OUT) begin : g_edge
            logic s3;

            // History flop so a level held high yields a single pulse.
            always_ff @(posedge clk or posedge res) begin
                if (res) s3 <= 1'b0;
                else     s3 <= s2;
            end

            assign rise = s2 & ~s3;
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/adc_serial_reader.sv
// Reads one DATA_W-bit word, MSB first, from the ADC serial port after each
// data-ready rising edge and presents it as a parallel sample with a strobe.
module adc_serial_reader
    import logger_pkg::*;
#(
    parameter int DATA_W    = ADC_DATA_W,
    parameter int SCLK_DIV  = ADC_SCLK_DIV,
    parameter int START_DLY = ADC_START_DLY
) (
    input  logic              clk,
    input  logic              res,
    adc_serial_reader_if.master bus
);
    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    adc_state_e        state;
    logic [7:0]        phase;
    logic [BCW-1:0]    bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] data_q;
    logic              sclk_q;
    logic              valid_q;
    logic              busy_q;
    logic              ovr_q;

    logic rdy_rise;
    logic rdy_lvl_unused;
    logic sdin_s;
    logic sdin_rise_unused;

    sync_edge_det #(.EDGE_OUT(1'b1)) u_drdy_sync (
        .clk  (clk),
        .res  (res),
        .d    (bus.nDRDY),
        .q    (rdy_lvl_unused),
        .rise (rdy_rise)
    );

    sync_edge_det #(.EDGE_OUT(1'b0)) u_sdin_sync (
        .clk  (clk),
        .res  (res),
        .d    (bus.SDIN1),
        .q    (sdin_s),
        .rise (sdin_rise_unused)
    );

    // Read sequencer: start delay, DATA_W high/low SCLK periods, then publish.
    // Outputs are registered; busy and the strobe trail the state by one cycle.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= ST_IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            data_q  <= '0;
            sclk_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            busy_q  <= (state != ST_IDLE);

            // A new edge outside IDLE (DONE included) is dropped and flagged;
            // setting takes priority over a clear in the same cycle.
            if (rdy_rise && state != ST_IDLE) ovr_q <= 1'b1;
            else if (bus.clr_ovr)             ovr_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rdy_rise && bus.en) begin
                        state <= ST_WAIT;
                        phase <= 8'(START_DLY - 1);
                    end
                end
                ST_WAIT: begin
                    if (phase == '0) begin
                        state   <= ST_HIGH;
                        sclk_q  <= 1'b1;
                        phase   <= 8'(SCLK_DIV - 1);
                        bit_cnt <= BCW'(DATA_W - 1);
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end
                ST_HIGH: begin
                    // Sample late in the high phase, far from the ADC's update.
                    if (phase == '0) begin
                        shreg  <= {shreg[DATA_W-2:0], sdin_s};
                        sclk_q <= 1'b0;
                        phase  <= 8'(SCLK_DIV - 1);
                        state  <= ST_LOW;
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end
                ST_LOW: begin
                    if (phase == '0) begin
                        if (bit_cnt == '0) begin
                            state <= ST_DONE;
                        end else begin
                            bit_cnt <= bit_cnt - BCW'(1);
                            sclk_q  <= 1'b1;
                            phase   <= 8'(SCLK_DIV - 1);
                            state   <= ST_HIGH;
                        end
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end
                ST_DONE: begin
                    data_q  <= shreg;
                    valid_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.SCLK1        = sclk_q;
    assign bus.sample_data  = data_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = ovr_q;
endmodule
